univ_shift_reg_n: RTL and testbench

UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

---
 rtl/univ_shift_reg_n.sv | 132 +++++++++++++
 tb/tb_univ_shift_reg_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Universal shift register: load/clear plus multi-step shift, rotate and arithmetic shift.
// Define USR_ROTATE_EN to enable ROL/ROR; otherwise they complete as a NOP.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] pi,
    input  logic             si,
    input  logic             pause,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_NOP  = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

`ifdef USR_ROTATE_EN
    localparam bit ROTATE_EN = 1'b1;
`else
    localparam bit ROTATE_EN = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] po_q, po_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       mode_q, mode_nxt;
    logic             dir_left, dir_nxt;
    logic             done_q, done_nxt;
    logic             is_step;

    function automatic logic [WIDTH-1:0] step(input logic [2:0] mode,
                                              input logic [WIDTH-1:0] v,
                                              input logic s);
        case (mode)
            M_SHL:   step = {v[WIDTH-2:0], s};
            M_SHR:   step = {s, v[WIDTH-1:1]};
            M_ROL:   step = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   step = {v[0], v[WIDTH-1:1]};
            M_ASR:   step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step = v;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            po_q     <= '0;
            cnt      <= '0;
            mode_q   <= M_NOP;
            dir_left <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            po_q     <= po_nxt;
            cnt      <= cnt_nxt;
            mode_q   <= mode_nxt;
            dir_left <= dir_nxt;
            done_q   <= done_nxt;
        end
    end

    // Rotates only count as multi-step modes when the rotate feature is built in.
    assign is_step = (cmd_mode == M_SHL) || (cmd_mode == M_SHR) || (cmd_mode == M_ASR) ||
                     (ROTATE_EN && ((cmd_mode == M_ROL) || (cmd_mode == M_ROR)));

    always_comb begin
        state_nxt = state;
        po_nxt    = po_q;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        dir_nxt   = dir_left;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_mode == M_LOAD) begin
                        po_nxt   = pi;
                        done_nxt = 1'b1;
                    end else if (cmd_mode == M_CLR) begin
                        po_nxt   = '0;
                        done_nxt = 1'b1;
                    end else if (is_step) begin
                        dir_nxt = (cmd_mode == M_SHL) || (cmd_mode == M_ROL);
                        if (cmd_count == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = RUN;
                            cnt_nxt   = cmd_count;
                            mode_nxt  = cmd_mode;
                        end
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!pause) begin
                    po_nxt  = step(mode_q, po_q, si);
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign po        = po_q;
    assign so        = dir_left ? po_q[WIDTH-1] : po_q[0];
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Randomized and directed bench for univ_shift_reg_n against a cycle-level reference model.
// Honors USR_ROTATE_EN the same way the design does.
module tb_univ_shift_reg_n;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_mode;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  pi;
    logic          si;
    logic          pause;
    logic [W-1:0]  po;
    logic          so;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    univ_shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_count(cmd_count), .pi(pi), .si(si),
        .pause(pause), .po(po), .so(so), .busy(busy), .done(done)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: register value, outstanding steps and the pending operation.
    logic [W-1:0] mPo   = '0;
    int           mRem  = 0;
    logic [2:0]   mMode = 3'd0;
    bit           mLeft = 1'b0;
    bit           mDone = 1'b0;

    function automatic logic [W-1:0] modelStep(input logic [2:0] m, input logic [W-1:0] v, input logic s);
        case (m)
            3'd1:    return W'(v << 1) | W'(s);
            3'd2:    return W'(v >> 1) | W'(W'(s) << (W - 1));
            3'd4:    return W'(v << 1) | W'(v >> (W - 1));
            3'd5:    return W'(v >> 1) | W'(v << (W - 1));
            3'd6:    return W'($signed(v) >>> 1);
            default: return v;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelUpdate(input bit v, input logic [2:0] m, input int k,
                               input logic [W-1:0] p, input bit s, input bit pz, input bit r);
        if (r) begin
            mPo = '0; mRem = 0; mLeft = 1'b0; mDone = 1'b0;
            return;
        end
        mDone = 1'b0;
        if (mRem > 0) begin
            if (!pz) begin
                mPo = modelStep(mMode, mPo, s);
                mRem--;
                if (mRem == 0) mDone = 1'b1;
            end
        end else if (v) begin
            if (m == 3'd3) begin
                mPo = p; mDone = 1'b1;
            end else if (m == 3'd7) begin
                mPo = '0; mDone = 1'b1;
            end else if (m == 3'd0 || ((m == 3'd4 || m == 3'd5) && !ROT_EN)) begin
                mDone = 1'b1;
            end else begin
                mLeft = (m == 3'd1 || m == 3'd4);
                if (k == 0) mDone = 1'b1;
                else begin
                    mRem = k; mMode = m;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, check just after it.
    task automatic applyStimulus(input bit v, input logic [2:0] m, input int k,
                                 input logic [W-1:0] p, input bit s, input bit pz, input bit r);
        cmd_valid = v; cmd_mode = m; cmd_count = CW'(k); pi = p; si = s; pause = pz; rst = r;
        @(posedge clk);
        modelUpdate(v, m, k, p, s, pz, r);
        #1;
        checkOutput("po", 32'(po), 32'(mPo));
        checkOutput("so", 32'(so), 32'(mLeft ? mPo[W-1] : mPo[0]));
        checkOutput("busy", 32'(busy), 32'(mRem > 0));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(mRem == 0));
        checkOutput("done", 32'(done), 32'(mDone));
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            applyStimulus(0, 3'd0, 0, '0, 0, 0, 0);
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        applyStimulus(0, 3'd0, 0, '0, 0, 0, 1);
        applyStimulus(1, 3'd3, 0, 8'hFF, 1, 1, 1);
        checkOutput("reset_po", 32'(po), 32'h0);
        checkOutput("reset_ready", 32'(cmd_ready), 32'h1);

        // Load then shift left three times with si=1.
        applyStimulus(1, 3'd3, 0, 8'hA5, 0, 0, 0);
        applyStimulus(1, 3'd1, 3, '0, 1, 0, 0);
        applyStimulus(0, 3'd0, 0, '0, 1, 0, 0);
        checkOutput("shl_step1", 32'(po), 32'h4B);
        applyStimulus(0, 3'd0, 0, '0, 1, 0, 0);
        checkOutput("shl_step2", 32'(po), 32'h97);
        applyStimulus(0, 3'd0, 0, '0, 1, 0, 0);
        checkOutput("shl_step3", 32'(po), 32'h2F);
        checkOutput("shl_done", 32'(done), 32'h1);
        checkOutput("shl_so", 32'(so), 32'h0);

        // Arithmetic shift right keeps the sign bit.
        applyStimulus(1, 3'd3, 0, 8'h90, 0, 0, 0);
        applyStimulus(1, 3'd6, 2, '0, 0, 0, 0);
        checkOutput("asr_busy", 32'(busy), 32'h1);
        waitIdle(10);
        checkOutput("asr_final", 32'(po), 32'hE4);

        // Rotate right by one, or NOP when rotates are not built in.
        applyStimulus(1, 3'd3, 0, 8'h81, 0, 0, 0);
        applyStimulus(1, 3'd5, 1, '0, 0, 0, 0);
        waitIdle(10);
        checkOutput("ror_final", 32'(po), ROT_EN ? 32'hC0 : 32'h81);

        // Paused shift right holds its value mid-operation.
        applyStimulus(1, 3'd3, 0, 8'hFF, 0, 0, 0);
        applyStimulus(1, 3'd2, 5, '0, 0, 0, 0);
        applyStimulus(0, 3'd0, 0, '0, 0, 0, 0);
        applyStimulus(0, 3'd0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3'd0, 0, '0, 0, 1, 0);
            checkOutput("shr_pause_hold", 32'(po), 32'h3F);
        end
        waitIdle(10);
        checkOutput("shr_final", 32'(po), 32'h07);

        // Reset mid-operation while a LOAD is held; the LOAD must wait for IDLE.
        applyStimulus(1, 3'd2, 5, '0, 0, 0, 0);
        applyStimulus(1, 3'd3, 0, 8'h5A, 0, 0, 0);
        applyStimulus(1, 3'd3, 0, 8'h5A, 0, 0, 0);
        checkOutput("run_ignores_load", 32'(po), 32'h01);
        applyStimulus(1, 3'd3, 0, 8'h5A, 0, 0, 1);
        checkOutput("rst_po", 32'(po), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        applyStimulus(0, 3'd0, 0, '0, 0, 0, 0);
        checkOutput("rst_no_done", 32'(done), 32'h0);

        // Zero-count shift completes immediately and done pulses back to back.
        applyStimulus(1, 3'd1, 0, '0, 1, 0, 0);
        applyStimulus(1, 3'd3, 0, 8'hC3, 0, 0, 0);
        checkOutput("zero_cnt_done", 32'(done), 32'h1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                          int'($urandom_range(0, 11)), W'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
